// File: rtl/demux_pkg.sv
// Shared definitions for the demux select sequencer.
// Channel-pick helpers walk an enable mask in ascending order.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    typedef struct packed {
        logic            wrap;
        logic [CH_W-1:0] ch;
    } ch_pick_t;

    function automatic logic [CH_W-1:0] first_ch(
        input logic [NUM_CH-1:0] mask
    );
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // wrap=1 means cur was the highest enabled channel
    function automatic ch_pick_t next_ch(
        input logic [CH_W-1:0]   cur,
        input logic [NUM_CH-1:0] mask
    );
        ch_pick_t r;
        r.wrap = 1'b1;
        r.ch   = first_ch(mask);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.wrap = 1'b0;
                r.ch   = CH_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux1_4.sv
// 1:4 demultiplexer driven by the select sequencer.
// Routes a onto the output picked by s; others stay low.
module demux1_4 (
    input  logic       a,
    input  logic [1:0] s,
    output logic       y0,
    output logic       y1,
    output logic       y2,
    output logic       y3
);

    assign y0 = a & (s == 2'd0);
    assign y1 = a & (s == 2'd1);
    assign y2 = a & (s == 2'd2);
    assign y3 = a & (s == 2'd3);

endmodule

// File: rtl/demux_select_seq.sv
// Sweeps the demux select over enabled channels with a dwell count.
// Forwards a registered copy of din to the demux while sweeping.
module demux_select_seq
    import demux_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               din,
    output logic               a,
    output logic [CH_W-1:0]    s,
    output logic               busy,
    output logic               sweep_done,
    output logic               err
);

    state_t              state, state_n;
    logic [DWELL_W-1:0]  cnt, cnt_n;
    logic [DWELL_W-1:0]  rel_q, rel_n;
    logic [NUM_CH-1:0]   mask_q, mask_n;
    logic                mode_q, mode_n;
    logic [CH_W-1:0]     s_n;
    logic                a_n, sd_n, err_n;
    logic [DWELL_W-1:0]  dwell_m1;
    ch_pick_t            pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rel_q      <= '0;
            mask_q     <= '0;
            mode_q     <= 1'b0;
            s          <= '0;
            a          <= 1'b0;
            sweep_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rel_q      <= rel_n;
            mask_q     <= mask_n;
            mode_q     <= mode_n;
            s          <= s_n;
            a          <= a_n;
            sweep_done <= sd_n;
            err        <= err_n;
        end
    end

    assign busy = (state == DWELL);

    // dwell of 0 behaves as 1, so the reload value saturates at 0
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign pick     = next_ch(s, mask_q);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rel_n   = rel_q;
        mask_n  = mask_q;
        mode_n  = mode_q;
        s_n     = s;
        a_n     = 1'b0;
        sd_n    = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                s_n = '0;
                if (start && !abort) begin
                    if (ch_mask == '0) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = DWELL;
                        mode_n  = mode;
                        mask_n  = ch_mask;
                        rel_n   = dwell_m1;
                        cnt_n   = dwell_m1;
                        s_n     = first_ch(ch_mask);
                    end
                end
            end
            DWELL: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    s_n     = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else begin
                    cnt_n = rel_q;
                    if (!pick.wrap) begin
                        s_n = pick.ch;
                    end else begin
                        sd_n = 1'b1;
                        if (mode_q) begin
                            s_n = pick.ch;
                        end else begin
                            state_n = IDLE;
                            s_n     = '0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == DWELL) a_n = din;
    end

endmodule
